// File: rtl/cmp_sort_ctrl.sv
// cmp_sort_ctrl: loads a frame of N nibbles, bubble-sorts it in place
// with one shared magnitude compare per cycle, then streams it out ascending.
module cmp_sort_ctrl #(
  parameter int N  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [3:0]    in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [3:0]    out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic [CW-1:0] swap_cnt
);

  localparam int PW = $clog2(N);
  localparam logic [PW-1:0] ZERO = '0;
  localparam logic [PW-1:0] ONE  = PW'(1);
  localparam logic [PW-1:0] LAST = PW'(N - 1);
  localparam logic [PW-1:0] JMAX = PW'(N - 2);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SORT = 2'd1,
    OUT  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   j_q, j_d;
  logic [PW-1:0]   pass_q, pass_d;
  logic            swap_flag_q, swap_flag_d;
  logic            out_valid_q, out_valid_d;
  logic [3:0]      out_data_q, out_data_d;
  logic [CW-1:0]   swap_cnt_q, swap_cnt_d;
  logic [3:0]      mem_q [N];

  logic [PW-1:0]   j1;
  logic [3:0]      cmp_a, cmp_b;
  logic            gt;
  logic            accept;
  logic            do_swap;
  logic            pass_end;

  // Shared comparator: only "greater" causes a swap, which keeps the sort stable.
  always_comb begin
    j1       = j_q + ONE;
    cmp_a    = mem_q[j_q];
    cmp_b    = mem_q[j1];
    gt       = cmp_a > cmp_b;
    accept   = in_valid && (state_q == LOAD);
    do_swap  = (state_q == SORT) && gt;
    pass_end = (j_q == (JMAX - pass_q));
  end

  // Next-state and datapath control for LOAD -> SORT -> OUT.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    j_d         = j_q;
    pass_d      = pass_q;
    swap_flag_d = swap_flag_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    swap_cnt_d  = swap_cnt_q;
    unique case (state_q)
      LOAD: begin
        if (accept) begin
          wr_ptr_d = wr_ptr_q + ONE;
          if (wr_ptr_q == LAST) begin
            state_d     = SORT;
            wr_ptr_d    = ZERO;
            j_d         = ZERO;
            pass_d      = ZERO;
            swap_flag_d = 1'b0;
            swap_cnt_d  = '0;
          end
        end
      end
      SORT: begin
        if (gt) begin
          swap_cnt_d  = swap_cnt_q + 1'b1;
          swap_flag_d = 1'b1;
        end
        if (pass_end) begin
          if ((!gt && !swap_flag_q) || (pass_q == JMAX)) begin
            state_d     = OUT;
            rd_ptr_d    = ZERO;
            out_valid_d = 1'b1;
            // mem[0] may be swapped on this very edge
            out_data_d  = (gt && (j_q == ZERO)) ? mem_q[ONE]
                                                : mem_q[ZERO];
          end else begin
            pass_d      = pass_q + ONE;
            j_d         = ZERO;
            swap_flag_d = 1'b0;
          end
        end else begin
          j_d = j1;
        end
      end
      OUT: begin
        if (out_ready) begin
          if (rd_ptr_q == LAST) begin
            state_d     = LOAD;
            rd_ptr_d    = ZERO;
            out_valid_d = 1'b0;
          end else begin
            rd_ptr_d   = rd_ptr_q + ONE;
            out_data_d = mem_q[rd_ptr_q + ONE];
          end
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // Control state register; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      j_q         <= '0;
      pass_q      <= '0;
      swap_flag_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      swap_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      j_q         <= j_d;
      pass_q      <= pass_d;
      swap_flag_q <= swap_flag_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      swap_cnt_q  <= swap_cnt_d;
    end
  end

  // Element storage: serial fill in LOAD, pairwise exchange in SORT.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= in_data;
    end else if (do_swap) begin
      mem_q[j_q] <= cmp_b;
      mem_q[j1]  <= cmp_a;
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign busy      = (state_q == SORT);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign swap_cnt  = swap_cnt_q;

endmodule

// File: doc/cmp_sort_ctrl.md
Name: cmp_sort_ctrl

Overview:
- Sequencer that time-shares one instance of the team's 4-bit magnitude comparator (outputs greater/lesser/equal) to bubble-sort a frame of N 4-bit values.
- Accepts a frame serially over a valid/ready input stream and sorts it in place, one compare per cycle.
- Streams the sorted frame out in ascending order over a valid/ready output stream.
- Sits between a sample source and any consumer needing ordered data (min/max/median selection).

Parameters:
- N, 8, frame length in 4-bit elements; legal range 2..16.
- CW, 8, width of swap_cnt; must hold N*(N-1)/2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  4  unsigned element.
- in_ready  output  1  block accepts an element this cycle.
- out_valid  output  1  out_data is valid.
- out_data  output  4  sorted element, ascending.
- out_ready  input  1  consumer accepts out_data.
- busy  output  1  high in SORT.
- swap_cnt  output  CW  number of swaps performed for the current frame.

Behaviour:
- Reset: one clock, reset asynchronous active-high. rst=1 immediately forces:
  - state=LOAD; wr_ptr, rd_ptr, j, pass = 0; swap_flag=0.
  - out_valid=0, out_data=0, busy=0, swap_cnt=0.
  - Element storage is not cleared. An in-progress frame is discarded on reset; no partial output.
- States are LOAD, SORT and OUT.
- LOAD:
  - in_ready=1. An element is accepted when in_valid && in_ready; it is written to mem[wr_ptr] and wr_ptr increments.
  - On the N-th accept: next state is SORT, wr_ptr=0, j=0, pass=0, swap_flag=0, swap_cnt=0.
  - in_ready=0 in every other state; in_valid is ignored there.
- SORT (busy=1):
  - Each cycle the comparator sees A=mem[j], B=mem[j+1].
  - If greater=1: swap mem[j] and mem[j+1] at the clock edge, swap_cnt+1, swap_flag=1.
  - equal=1 or lesser=1: no swap, so the sort is stable.
  - Pass end occurs when j == N-2-pass:
    - If that cycle swapped nothing and swap_flag=0, or if pass == N-2: go to OUT with rd_ptr=0.
    - Otherwise: pass+1, j=0, swap_flag=0.
  - Not at pass end: j+1.
  - Latency, last LOAD accept to first out_valid:
    - Already-sorted frame: N-1 cycles (one pass).
    - Worst case (reverse-sorted frame): N*(N-1)/2 cycles, i.e. 28 for N=8.
- OUT:
  - out_valid=1, out_data=mem[rd_ptr], registered; out_data is valid in the first OUT cycle.
  - On out_valid && out_ready: rd_ptr+1 and out_data updates to the next element.
  - After the N-th transfer: out_valid=0, next state LOAD.
  - out_data holds stable while out_ready=0.
  - swap_cnt holds its value through OUT and LOAD until the next frame enters SORT.
- No overlap: a new frame cannot load while OUT is draining. in_ready first rises the cycle after the last output transfer.
- Arithmetic is unsigned 4-bit; 4'hF is the maximum. Duplicates are allowed.

Test Plan:
- Reset behaviour: assert rst mid-SORT -> busy=0, out_valid=0, swap_cnt=0 without waiting for a clock edge; in_ready=1 on release.
- Reverse-sorted frame F,E,D,C,B,A,9,8 -> out 8,9,A,B,C,D,E,F; swap_cnt=28; SORT lasts exactly 28 cycles.
- Sorted frame 0,1,2,3,4,5,6,7 -> SORT lasts 7 cycles; swap_cnt=0; output identical to input.
- Duplicates 5,9,5,0,F,5,0,9 -> out 0,0,5,5,5,9,9,F; in_valid held high during SORT/OUT is not consumed (in_ready=0).
- Backpressure: toggle out_ready 1,0,0,1,... during OUT -> out_data stable while stalled; exactly N transfers; in_ready rises one cycle after the last transfer.
- Gapped input: in_valid low for random cycles during LOAD -> SORT entered only after the 8th accepted element; result still correct.
